// File: rtl/reg_pipe_pkg.sv
// rtl/reg_pipe_pkg.sv - shared constants and helpers for the register pipe chain
package reg_pipe_pkg;

    localparam int MAX_DEPTH = 8;

    // Bits needed to count 0..depth.
    // Never narrower than 1 bit, so a DEPTH=0 build still has a legal vector.
    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// rtl/reg_pipe_stage.sv - one register stage (data + valid) of the pipe chain
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset: clears data and valid
//   ce       clock enable: load d/d_valid when set
//   flush    synchronous invalidate: clears valid, holds data, beats ce
//   d        data in, WIDTH bits
//   d_valid  qualifier for d
//   q        registered data out
//   q_valid  registered qualifier out
module reg_pipe_stage #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            // Data is left in place; only the qualifier is dropped.
            q_valid <= 1'b0;
        end else if (ce) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/reg_pipe_chain.sv
// rtl/reg_pipe_chain.sv - DEPTH-stage register pipe with clock enable, flush and prime flag
//
// Parameters:
//   WIDTH    data width in bits (1..48)
//   DEPTH    number of register stages (0..8); 0 is a combinational wire-through
//
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset (beats FLUSH and CE)
//   CE       clock enable for every stage and for the prime counter
//   FLUSH    synchronous invalidate of all stages and of the prime counter
//   D        data in
//   D_VALID  qualifier for D
//   Q        data out, DEPTH enabled cycles after D
//   Q_VALID  qualifier for Q
//   PRIMED   chain has shifted at least DEPTH times since the last reset/flush
//   OCC      number of stages holding valid data (only with REG_PIPE_OCCUPANCY_EN)
//
// Optional feature macro: REG_PIPE_OCCUPANCY_EN adds the OCC output.
module reg_pipe_chain
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CE,
    input  logic                        FLUSH,
    input  logic [WIDTH-1:0]            D,
    input  logic                        D_VALID,
    output logic [WIDTH-1:0]            Q,
    output logic                        Q_VALID,
`ifdef REG_PIPE_OCCUPANCY_EN
    output logic                        PRIMED,
    output logic [cnt_width(DEPTH)-1:0] OCC
`else
    output logic                        PRIMED
`endif
);

    localparam int CW = cnt_width(DEPTH);

    generate
        if (DEPTH < 0 || DEPTH > MAX_DEPTH || WIDTH < 1 || WIDTH > 48) begin : g_bad_cfg
            $error("reg_pipe_chain: unsupported WIDTH/DEPTH combination");
        end

        if (DEPTH == 0) begin : g_wire
            assign Q       = D;
            assign Q_VALID = D_VALID;
            assign PRIMED  = 1'b1;
`ifdef REG_PIPE_OCCUPANCY_EN
            assign OCC     = '0;
`endif
        end else begin : g_pipe
            localparam logic [CW-1:0] FULL = CW'(DEPTH);

            // Index 0 is the chain input; index k is the output of stage k.
            logic [WIDTH-1:0] data  [0:DEPTH];
            logic             valid [0:DEPTH];
            logic [CW-1:0]    prime_cnt;

            assign data[0]  = D;
            assign valid[0] = D_VALID;

            for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
                reg_pipe_stage #(
                    .WIDTH(WIDTH)
                ) u_stage (
                    .clk     (CLK),
                    .rst     (RST),
                    .ce      (CE),
                    .flush   (FLUSH),
                    .d       (data[k-1]),
                    .d_valid (valid[k-1]),
                    .q       (data[k]),
                    .q_valid (valid[k])
                );
            end

            // Counts enabled shifts since reset/flush, stopping at DEPTH.
            always_ff @(posedge CLK) begin
                if (RST || FLUSH) begin
                    prime_cnt <= '0;
                end else if (CE && (prime_cnt != FULL)) begin
                    prime_cnt <= prime_cnt + CW'(1);
                end
            end

            assign Q       = data[DEPTH];
            assign Q_VALID = valid[DEPTH];
            assign PRIMED  = (prime_cnt == FULL);

`ifdef REG_PIPE_OCCUPANCY_EN
            logic [CW-1:0] occ_cnt;

            // On a shift one valid bit enters and the last stage's bit leaves,
            // so a running count tracks the population without a popcount.
            // occ_cnt >= valid[DEPTH] always holds, so the subtraction never wraps.
            always_ff @(posedge CLK) begin
                if (RST || FLUSH) begin
                    occ_cnt <= '0;
                end else if (CE) begin
                    occ_cnt <= occ_cnt + CW'(D_VALID) - CW'(valid[DEPTH]);
                end
            end

            assign OCC = occ_cnt;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_reg_pipe_chain.sv
// tb/tb_reg_pipe_chain.sv - scoreboard testbench for reg_pipe_chain
module tb_reg_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DEPTH=2 instance, checked by the scoreboard monitor
    logic        rst2, ce2, flush2, dv2;
    logic [17:0] d2, q2;
    logic        qv2, pr2;
    // DEPTH=3 instance, CE gap latency
    logic        rst3, ce3, flush3, dv3;
    logic [17:0] d3, q3;
    logic        qv3, pr3;
    // DEPTH=0 instance, wire-through
    logic        rst0, ce0, flush0, dv0;
    logic [17:0] d0, q0;
    logic        qv0, pr0;
    // DEPTH=4 instance, occupancy pattern
    logic        rst4, ce4, flush4, dv4;
    logic [17:0] d4, q4;
    logic        qv4, pr4;
`ifdef REG_PIPE_OCCUPANCY_EN
    logic [1:0]  occ2;
    logic [1:0]  occ3;
    logic [0:0]  occ0;
    logic [2:0]  occ4;
`endif

    reg_pipe_chain #(.WIDTH(18), .DEPTH(2)) u_dut2 (
        .CLK(clk), .RST(rst2), .CE(ce2), .FLUSH(flush2), .D(d2), .D_VALID(dv2),
`ifdef REG_PIPE_OCCUPANCY_EN
        .OCC(occ2),
`endif
        .Q(q2), .Q_VALID(qv2), .PRIMED(pr2)
    );

    reg_pipe_chain #(.WIDTH(18), .DEPTH(3)) u_dut3 (
        .CLK(clk), .RST(rst3), .CE(ce3), .FLUSH(flush3), .D(d3), .D_VALID(dv3),
`ifdef REG_PIPE_OCCUPANCY_EN
        .OCC(occ3),
`endif
        .Q(q3), .Q_VALID(qv3), .PRIMED(pr3)
    );

    reg_pipe_chain #(.WIDTH(18), .DEPTH(0)) u_dut0 (
        .CLK(clk), .RST(rst0), .CE(ce0), .FLUSH(flush0), .D(d0), .D_VALID(dv0),
`ifdef REG_PIPE_OCCUPANCY_EN
        .OCC(occ0),
`endif
        .Q(q0), .Q_VALID(qv0), .PRIMED(pr0)
    );

    reg_pipe_chain #(.WIDTH(18), .DEPTH(4)) u_dut4 (
        .CLK(clk), .RST(rst4), .CE(ce4), .FLUSH(flush4), .D(d4), .D_VALID(dv4),
`ifdef REG_PIPE_OCCUPANCY_EN
        .OCC(occ4),
`endif
        .Q(q4), .Q_VALID(qv4), .PRIMED(pr4)
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the DEPTH=2 instance
    logic [17:0] exp_q[$];
    logic [17:0] exp_word;
    logic        shifted = 1'b0;

    always @(posedge clk) shifted <= ce2 && !flush2 && !rst2;

    always @(negedge clk) begin
        if (shifted && qv2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL q2_unexpected: got word %h, expected no output", q2);
            end else begin
                exp_word = exp_q.pop_front();
                chk("q2_data", 48'(q2), 48'(exp_word));
            end
        end
    end

    logic [17:0] stream_d [4] = '{18'h00155, 18'h00000, 18'h002AA, 18'h3FFFF};
    logic        stream_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        ce3_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        v4_pat   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  occ4_exp [4] = '{3'd1, 3'd1, 3'd2, 3'd3};

    initial begin
        rst2 = 1; ce2 = 0; flush2 = 0; d2 = '0; dv2 = 0;
        rst3 = 1; ce3 = 0; flush3 = 0; d3 = '0; dv3 = 0;
        rst0 = 0; ce0 = 0; flush0 = 0; d0 = '0; dv0 = 0;
        rst4 = 1; ce4 = 0; flush4 = 0; d4 = '0; dv4 = 0;
        cyc();
        cyc();

        // Reset state
        chk("rst_q", 48'(q2), 48'h0);
        chk("rst_q_valid", 48'(qv2), 48'h0);
        chk("rst_primed", 48'(pr2), 48'h0);
        chk("rst_d3_q_valid", 48'(qv3), 48'h0);

        // Single word, latency 2, PRIMED from the second edge
        rst2 = 0; ce2 = 1; d2 = 18'h00011; dv2 = 1; exp_q.push_back(18'h00011);
        cyc();
        chk("lat_primed_e1", 48'(pr2), 48'h0);
        chk("lat_q_valid_e1", 48'(qv2), 48'h0);
        dv2 = 0; d2 = '0;
        cyc();
        chk("lat_q_valid_e2", 48'(qv2), 48'h1);
        chk("lat_primed_e2", 48'(pr2), 48'h1);

        // Stream with bubbles and CE=0 gaps between words
        for (int i = 0; i < 4; i++) begin
            d2 = stream_d[i]; dv2 = stream_v[i]; ce2 = 1;
            if (stream_v[i]) exp_q.push_back(stream_d[i]);
            cyc();
            ce2 = 0; dv2 = 0;
            cyc();
        end
        ce2 = 1; dv2 = 0; d2 = '0;
        cyc(); cyc(); cyc();

        // CE=0 holds Q
        d2 = 18'h0F0F0; dv2 = 1; exp_q.push_back(18'h0F0F0);
        cyc();
        dv2 = 0; d2 = '0;
        cyc();
        ce2 = 0;
        cyc(); cyc(); cyc();
        chk("hold_q", 48'(q2), 48'h0F0F0);
        chk("hold_q_valid", 48'(qv2), 48'h1);
        ce2 = 1;
        cyc(); cyc();

        // Flush with two words in flight; flush beats CE and drops D_VALID
        d2 = 18'h01234; dv2 = 1; exp_q.push_back(18'h01234);
        cyc();
        d2 = 18'h00ABC;
        cyc();
        flush2 = 1; ce2 = 1; d2 = 18'h00777; dv2 = 1;
        cyc();
        chk("flush_q_held", 48'(q2), 48'h01234);
        chk("flush_q_valid", 48'(qv2), 48'h0);
        chk("flush_primed", 48'(pr2), 48'h0);
`ifdef REG_PIPE_OCCUPANCY_EN
        chk("flush_occ", 48'(occ2), 48'h0);
`endif
        flush2 = 0; dv2 = 0; d2 = '0;
        cyc();
        chk("reprime_e1", 48'(pr2), 48'h0);
        cyc();
        chk("reprime_e2", 48'(pr2), 48'h1);
        chk("flush_no_ghost", 48'(qv2), 48'h0);

        // Reset beats FLUSH and CE, then a fresh word after 2 edges
        d2 = 18'h00099; dv2 = 1;
        cyc();
        rst2 = 1; flush2 = 1; ce2 = 1; d2 = 18'h00055; dv2 = 1;
        cyc();
        chk("rstpri_q", 48'(q2), 48'h0);
        chk("rstpri_q_valid", 48'(qv2), 48'h0);
        chk("rstpri_primed", 48'(pr2), 48'h0);
        rst2 = 0; flush2 = 0; d2 = 18'h00005; dv2 = 1; exp_q.push_back(18'h00005);
        cyc();
        chk("post_rst_e1_valid", 48'(qv2), 48'h0);
        dv2 = 0; d2 = '0;
        cyc();
        chk("post_rst_q", 48'(q2), 48'h00005);
        chk("post_rst_primed", 48'(pr2), 48'h1);
        cyc(); cyc();

        // DEPTH=3 with CE pattern 1,0,0,1,1
        rst3 = 0;
        for (int i = 0; i < 5; i++) begin
            ce3 = ce3_pat[i];
            d3  = (i == 0) ? 18'h3FFFF : 18'h0;
            dv3 = (i == 0);
            cyc();
            if (i < 4) begin
                chk($sformatf("d3_early_valid_%0d", i), 48'(qv3), 48'h0);
            end else begin
                chk("d3_q", 48'(q3), 48'h3FFFF);
                chk("d3_q_valid", 48'(qv3), 48'h1);
                chk("d3_primed", 48'(pr3), 48'h1);
            end
        end

        // DEPTH=0 wire-through ignores RST/FLUSH
        d0 = 18'h2AAAA; dv0 = 1; rst0 = 1; flush0 = 1; ce0 = 0;
        #1;
        chk("d0_q", 48'(q0), 48'h2AAAA);
        chk("d0_q_valid", 48'(qv0), 48'h1);
        chk("d0_primed", 48'(pr0), 48'h1);
        cyc();
        chk("d0_q_after_edge", 48'(q0), 48'h2AAAA);

`ifdef REG_PIPE_OCCUPANCY_EN
        // DEPTH=4 occupancy, valid pattern 1,0,1,1
        rst4 = 0; ce4 = 1;
        for (int i = 0; i < 4; i++) begin
            d4 = 18'(i + 1); dv4 = v4_pat[i];
            cyc();
            chk($sformatf("occ4_%0d", i), 48'(occ4), 48'(occ4_exp[i]));
        end
        flush4 = 1; dv4 = 0;
        cyc();
        chk("occ4_flush", 48'(occ4), 48'h0);
        flush4 = 0;
`endif

        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
